// File: rtl/dmem_xlate_if.sv
// Bus between the load/store address stage, the MMU data port, the dcache and CP0
// as seen by the data-side translation stage.
interface dmem_xlate_if #(parameter int PADDR_W = 32);
  logic               req_valid;
  logic               req_ready;
  logic [31:0]        req_vaddr;
  logic               req_wr;
  logic [1:0]         req_size;
  logic [31:0]        req_wdata;
  logic [3:0]         req_wstrb;
  logic               tlb_found;
  logic               tlb_v;
  logic               tlb_d;
  logic               tlb_uncache;
  logic [19:0]        mmu_pfn;
  logic               dc_valid;
  logic               dc_ready;
  logic [PADDR_W-1:0] dc_paddr;
  logic               dc_uncache;
  logic               dc_wr;
  logic [1:0]         dc_size;
  logic [31:0]        dc_wdata;
  logic [3:0]         dc_wstrb;
  logic               exc_valid;
  logic [4:0]         exc_code;
  logic               exc_refill;
  logic [31:0]        exc_badvaddr;

  // master: upstream pipeline + MMU + dcache + CP0 environment; slave: the stage
  modport master (
    output req_valid, req_vaddr, req_wr, req_size, req_wdata, req_wstrb,
           tlb_found, tlb_v, tlb_d, tlb_uncache, mmu_pfn, dc_ready,
    input  req_ready, dc_valid, dc_paddr, dc_uncache, dc_wr, dc_size,
           dc_wdata, dc_wstrb, exc_valid, exc_code, exc_refill, exc_badvaddr
  );

  modport slave (
    input  req_valid, req_vaddr, req_wr, req_size, req_wdata, req_wstrb,
           tlb_found, tlb_v, tlb_d, tlb_uncache, mmu_pfn, dc_ready,
    output req_ready, dc_valid, dc_paddr, dc_uncache, dc_wr, dc_size,
           dc_wdata, dc_wstrb, exc_valid, exc_code, exc_refill, exc_badvaddr
  );
endinterface

// File: rtl/dmem_xlate_stage.sv
// Data-side translation stage: one request slot that joins the late MMU pfn with the
// request, classifies address/TLB exceptions, and issues to the dcache or to CP0.
module dmem_xlate_stage #(
  parameter int PADDR_W = 32
) (
  input logic         clk,
  input logic         rst,
  input logic         flush,
  dmem_xlate_if.slave bus
);
  localparam logic [4:0] EXC_MOD  = 5'd1;
  localparam logic [4:0] EXC_TLBL = 5'd2;
  localparam logic [4:0] EXC_TLBS = 5'd3;
  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_ADES = 5'd5;

  logic        s1_valid;
  logic        s1_exc;
  logic [4:0]  s1_code;
  logic        s1_refill;
  logic [31:0] s1_vaddr;
  logic        s1_wr;
  logic [1:0]  s1_size;
  logic [31:0] s1_wdata;
  logic [3:0]  s1_wstrb;
  logic        s1_uncache;
  logic        s1_fresh;
  logic [19:0] s1_pfn_hold;

  logic        accept;
  logic        misaligned;
  logic        exc_next;
  logic [4:0]  code_next;
  logic        refill_next;
  logic [19:0] pfn_cur;

  // Handshakes: a transfer happens on a cycle where valid and ready are both high;
  // a valid request holds all its payload stable until that cycle.
  assign bus.req_ready = !flush && (!s1_valid || s1_exc || bus.dc_ready);
  assign accept        = bus.req_valid && bus.req_ready;

  always_comb begin
    misaligned = 1'b0;
    case (bus.req_size)
      2'd0:    misaligned = 1'b0;
      2'd1:    misaligned = bus.req_vaddr[0];
      default: misaligned = |bus.req_vaddr[1:0];
    endcase

    exc_next    = 1'b1;
    refill_next = 1'b0;
    code_next   = bus.req_wr ? EXC_ADES : EXC_ADEL;
    if (misaligned) begin
      code_next = bus.req_wr ? EXC_ADES : EXC_ADEL;
    end else if (!bus.tlb_found) begin
      code_next   = bus.req_wr ? EXC_TLBS : EXC_TLBL;
      refill_next = 1'b1;
    end else if (!bus.tlb_v) begin
      code_next = bus.req_wr ? EXC_TLBS : EXC_TLBL;
    end else if (bus.req_wr && !bus.tlb_d) begin
      code_next = EXC_MOD;
    end else begin
      exc_next  = 1'b0;
      code_next = 5'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid    <= 1'b0;
      s1_exc      <= 1'b0;
      s1_code     <= 5'd0;
      s1_refill   <= 1'b0;
      s1_vaddr    <= 32'd0;
      s1_wr       <= 1'b0;
      s1_size     <= 2'd0;
      s1_wdata    <= 32'd0;
      s1_wstrb    <= 4'd0;
      s1_uncache  <= 1'b0;
      s1_fresh    <= 1'b0;
      s1_pfn_hold <= 20'd0;
    end else begin
      // The MMU pfn is only valid in the first slot cycle; keep it for stalls.
      if (s1_fresh) s1_pfn_hold <= bus.mmu_pfn;
      s1_fresh <= accept;
      if (accept) begin
        s1_valid   <= 1'b1;
        s1_exc     <= exc_next;
        s1_code    <= code_next;
        s1_refill  <= refill_next;
        s1_vaddr   <= bus.req_vaddr;
        s1_wr      <= bus.req_wr;
        s1_size    <= bus.req_size;
        s1_wdata   <= bus.req_wdata;
        s1_wstrb   <= bus.req_wstrb;
        s1_uncache <= bus.tlb_uncache;
      end else if (flush || s1_exc || bus.dc_ready) begin
        s1_valid <= 1'b0;
      end
    end
  end

  assign pfn_cur          = s1_fresh ? bus.mmu_pfn : s1_pfn_hold;
  assign bus.dc_valid     = s1_valid && !s1_exc;
  assign bus.dc_paddr     = PADDR_W'({pfn_cur, s1_vaddr[11:0]});
  assign bus.dc_uncache   = s1_uncache;
  assign bus.dc_wr        = s1_wr;
  assign bus.dc_size      = s1_size;
  assign bus.dc_wdata     = s1_wdata;
  assign bus.dc_wstrb     = s1_wstrb;
  assign bus.exc_valid    = s1_valid && s1_exc && !flush;
  assign bus.exc_code     = s1_code;
  assign bus.exc_refill   = s1_refill;
  assign bus.exc_badvaddr = s1_vaddr;
endmodule

// File: tb/tb_dmem_xlate_stage.sv
// Directed and randomized checks of dmem_xlate_stage against a transaction-level
// model of the address-translation and exception rules.
module tb_dmem_xlate_stage;
  logic clk = 1'b0;
  logic rst;
  logic flush;
  int   n_tests = 0;
  int   n_fail  = 0;
  logic [31:0] exp_q[$];

  dmem_xlate_if #(.PADDR_W(32)) bus ();

  dmem_xlate_stage #(.PADDR_W(32)) dut (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference classification: alignment in bytes, then MMU lookup result.
  task automatic classify(input logic [31:0] va, input logic wr, input logic [1:0] sz,
                          input logic f, input logic v, input logic d,
                          output logic e, output logic [4:0] code, output logic refill);
    int nbytes;
    nbytes = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    e = 1'b1;
    refill = 1'b0;
    if ((va % nbytes) != 0)  code = wr ? 5'd5 : 5'd4;
    else if (!f) begin       code = wr ? 5'd3 : 5'd2; refill = 1'b1; end
    else if (!v)             code = wr ? 5'd3 : 5'd2;
    else if (wr && !d)       code = 5'd1;
    else begin               code = 5'd0; e = 1'b0; end
  endtask

  task automatic drive_req(input logic [31:0] va, input logic wr, input logic [1:0] sz,
                           input logic f, input logic v, input logic d, input logic unc,
                           input logic [31:0] wd, input logic [3:0] ws);
    bus.req_valid   = 1'b1;
    bus.req_vaddr   = va;
    bus.req_wr      = wr;
    bus.req_size    = sz;
    bus.req_wdata   = wd;
    bus.req_wstrb   = ws;
    bus.tlb_found   = f;
    bus.tlb_v       = v;
    bus.tlb_d       = d;
    bus.tlb_uncache = unc;
  endtask

  // One full transaction: accept, then either an exception pulse or a dcache
  // request stalled for 'stall' cycles while mmu_pfn wanders to stall_pfn.
  task automatic do_req(input logic [31:0] va, input logic wr, input logic [1:0] sz,
                        input logic f, input logic v, input logic d, input logic unc,
                        input logic [19:0] pfn, input int stall, input logic [19:0] stall_pfn);
    logic e, r;
    logic [4:0] c;
    logic [31:0] wd, ex;
    logic [3:0] ws;
    wd = $urandom;
    ws = 4'($urandom_range(0, 15));
    classify(va, wr, sz, f, v, d, e, c, r);
    tick();
    drive_req(va, wr, sz, f, v, d, unc, wd, ws);
    bus.mmu_pfn  = 20'($urandom);
    bus.dc_ready = 1'b0;
    #1 chk("accept_ready", 32'(bus.req_ready), 32'd1);
    tick();
    bus.req_valid = 1'b0;
    bus.mmu_pfn   = pfn;
    bus.dc_ready  = (stall == 0);
    #1;
    if (e) begin
      chk("exc_valid", 32'(bus.exc_valid), 32'd1);
      chk("exc_code", 32'(bus.exc_code), 32'(c));
      chk("exc_refill", 32'(bus.exc_refill), 32'(r));
      chk("exc_badvaddr", bus.exc_badvaddr, va);
      chk("exc_no_dc", 32'(bus.dc_valid), 32'd0);
      tick();
      bus.dc_ready = 1'b0;
      #1;
      chk("exc_one_cycle", 32'(bus.exc_valid), 32'd0);
      chk("exc_after_no_dc", 32'(bus.dc_valid), 32'd0);
    end else begin
      exp_q.push_back({pfn, va[11:0]});
      for (int k = 0; k <= stall; k++) begin
        if (k > 0) begin
          tick();
          bus.mmu_pfn  = stall_pfn;
          bus.dc_ready = (k == stall);
          #1;
        end
        chk("dc_valid", 32'(bus.dc_valid), 32'd1);
        chk("dc_no_exc", 32'(bus.exc_valid), 32'd0);
        chk("stall_ready", 32'(bus.req_ready), 32'(k == stall));
        chk("dc_wr", 32'(bus.dc_wr), 32'(wr));
        chk("dc_size", 32'(bus.dc_size), 32'(sz));
        chk("dc_wdata", bus.dc_wdata, wd);
        chk("dc_wstrb", 32'(bus.dc_wstrb), 32'(ws));
        chk("dc_uncache", 32'(bus.dc_uncache), 32'(unc));
        if (exp_q.size() == 0) chk("dc_paddr_queue", 32'd0, 32'd1);
        else begin
          ex = (k == stall) ? exp_q.pop_front() : exp_q[0];
          chk("dc_paddr", bus.dc_paddr, ex);
        end
      end
      tick();
      bus.dc_ready = 1'b0;
      #1 chk("dc_done", 32'(bus.dc_valid), 32'd0);
    end
  endtask

  initial begin
    logic [31:0] va4[4];
    logic [19:0] pf4[4];
    logic [31:0] ex;
    rst   = 1'b1;
    flush = 1'b0;
    drive_req(32'd0, 1'b0, 2'd0, 1'b1, 1'b1, 1'b1, 1'b0, 32'd0, 4'd0);
    bus.req_valid = 1'b0;
    bus.mmu_pfn   = 20'd0;
    bus.dc_ready  = 1'b0;
    tick();
    tick();
    chk("rst_dc_valid", 32'(bus.dc_valid), 32'd0);
    chk("rst_exc_valid", 32'(bus.exc_valid), 32'd0);
    chk("rst_exc_code", 32'(bus.exc_code), 32'd0);
    chk("rst_exc_refill", 32'(bus.exc_refill), 32'd0);
    chk("rst_dc_paddr", bus.dc_paddr, 32'd0);
    chk("rst_badvaddr", bus.exc_badvaddr, 32'd0);
    rst = 1'b0;

    // Plain load, then the same load stalled while the MMU output changes.
    do_req(32'h0040_1234, 1'b0, 2'd2, 1'b1, 1'b1, 1'b0, 1'b0, 20'h1F000, 0, 20'h0);
    do_req(32'h0040_1234, 1'b0, 2'd2, 1'b1, 1'b1, 1'b0, 1'b0, 20'h1F000, 3, 20'hAAAAA);
    // TLB refill on store, Mod, and AdEL winning over a dead TLB lookup.
    do_req(32'h0000_2000, 1'b1, 2'd2, 1'b0, 1'b0, 1'b0, 1'b0, 20'h12345, 0, 20'h0);
    do_req(32'h0000_3000, 1'b1, 2'd2, 1'b1, 1'b1, 1'b0, 1'b0, 20'h12345, 0, 20'h0);
    do_req(32'h8000_0001, 1'b0, 2'd1, 1'b0, 1'b0, 1'b0, 1'b0, 20'h12345, 0, 20'h0);
    do_req(32'h0000_4000, 1'b0, 2'd2, 1'b1, 1'b0, 1'b1, 1'b0, 20'h12345, 0, 20'h0);

    // Four back-to-back loads, each pairing with its own late pfn.
    for (int i = 0; i < 4; i++) begin
      va4[i] = 32'h1000_0000 + 32'(i) * 32'h0000_0104;
      pf4[i] = 20'h30000 + 20'(i) * 20'h00111;
    end
    for (int i = 0; i <= 4; i++) begin
      tick();
      if (i < 4) begin
        drive_req(va4[i], 1'b0, 2'd2, 1'b1, 1'b1, 1'b1, 1'b0, 32'd0, 4'hF);
        exp_q.push_back({pf4[i], va4[i][11:0]});
      end else bus.req_valid = 1'b0;
      bus.mmu_pfn  = (i > 0) ? pf4[i-1] : 20'h0;
      bus.dc_ready = 1'b1;
      #1;
      if (i < 4) chk("b2b_ready", 32'(bus.req_ready), 32'd1);
      if (i > 0) begin
        chk("b2b_dc_valid", 32'(bus.dc_valid), 32'd1);
        ex = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hDEAD_BEEF;
        chk("b2b_paddr", bus.dc_paddr, ex);
      end
    end
    tick();
    bus.dc_ready = 1'b0;
    #1 chk("b2b_drained", 32'(bus.dc_valid), 32'd0);

    // Flush kills a stalled load.
    tick();
    drive_req(32'h0000_5678, 1'b0, 2'd2, 1'b1, 1'b1, 1'b1, 1'b0, 32'd0, 4'hF);
    tick();
    bus.req_valid = 1'b0;
    bus.mmu_pfn   = 20'h55555;
    #1 chk("fl_pre_valid", 32'(bus.dc_valid), 32'd1);
    tick();
    flush = 1'b1;
    #1 chk("fl_ready_low", 32'(bus.req_ready), 32'd0);
    tick();
    flush = 1'b0;
    #1;
    chk("fl_dc_valid", 32'(bus.dc_valid), 32'd0);
    chk("fl_exc_valid", 32'(bus.exc_valid), 32'd0);
    chk("fl_ready", 32'(bus.req_ready), 32'd1);

    // Flush in the pulse cycle suppresses the exception.
    tick();
    drive_req(32'h0000_6000, 1'b1, 2'd2, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 4'hF);
    tick();
    bus.req_valid = 1'b0;
    flush = 1'b1;
    #1 chk("fl_exc_masked", 32'(bus.exc_valid), 32'd0);
    tick();
    flush = 1'b0;
    #1;
    chk("fl_exc_gone", 32'(bus.exc_valid), 32'd0);
    chk("fl_exc_ready", 32'(bus.req_ready), 32'd1);

    // Reset mid-stall drops the request silently.
    tick();
    drive_req(32'h0000_7000, 1'b0, 2'd2, 1'b1, 1'b1, 1'b1, 1'b0, 32'd0, 4'hF);
    tick();
    bus.req_valid = 1'b0;
    #1 chk("rs_pre_valid", 32'(bus.dc_valid), 32'd1);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    chk("rs_dc_valid", 32'(bus.dc_valid), 32'd0);
    chk("rs_exc_valid", 32'(bus.exc_valid), 32'd0);
    chk("rs_ready", 32'(bus.req_ready), 32'd1);

    // Randomized transactions against the model.
    exp_q.delete();
    for (int n = 0; n < 60; n++) begin
      do_req($urandom, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
             ($urandom_range(0, 5) != 0), ($urandom_range(0, 5) != 0),
             ($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
             20'($urandom), $urandom_range(0, 3), 20'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
